// File: rtl/stream_take_sum.sv
// Pulls N elements from a stream after a start handshake and returns their sum.
// Define STREAM_TAKE_SUM_SAT_EN to saturate the accumulator instead of wrapping.
module stream_take_sum #(
  parameter int unsigned intN = 8,
  parameter int unsigned CNTW = intN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [intN-1:0] dIn,
  input  logic [intN-1:0] sIn,
  input  logic            sIn_valid,
  output logic            sIn_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [intN-1:0] dOut
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [intN-1:0] r_acc;
  logic [intN-1:0] r_dout;
  logic            r_in_ready;
  logic            r_sin_ready;
  logic            r_out_valid;

  logic [CNTW-1:0] w_start_cnt;
  logic [intN-1:0] w_sum;

  // Negative counts collapse to zero.
  assign w_start_cnt = dIn[intN-1] ? '0 : CNTW'(dIn);

`ifdef STREAM_TAKE_SUM_SAT_EN
  logic [intN:0] w_wide;
  assign w_wide = {r_acc[intN-1], r_acc} + {sIn[intN-1], sIn};
  always_comb begin
    w_sum = w_wide[intN-1:0];
    if (w_wide[intN] != w_wide[intN-1]) begin
      w_sum = w_wide[intN] ? {1'b1, {(intN-1){1'b0}}} : {1'b0, {(intN-1){1'b1}}};
    end
  end
`else
  assign w_sum = r_acc + sIn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_dout      <= '0;
      r_in_ready  <= 1'b1;
      r_sin_ready <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_acc      <= '0;
            r_cnt      <= w_start_cnt;
            r_dout     <= '0;
            r_in_ready <= 1'b0;
            if (w_start_cnt == '0) begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= StRun;
              r_sin_ready <= 1'b1;
            end
          end
        end
        StRun: begin
          if (sIn_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - CNTW'(1);
            if (r_cnt == CNTW'(1)) begin
              r_state     <= StDone;
              r_dout      <= w_sum;
              r_sin_ready <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_dout      <= '0;
          r_in_ready  <= 1'b1;
          r_sin_ready <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign sIn_ready = r_sin_ready;
  assign out_valid = r_out_valid;
  assign dOut      = r_dout;

endmodule

// File: tb/tb_stream_take_sum.sv
// Directed and randomised checks for stream_take_sum; honours STREAM_TAKE_SUM_SAT_EN.
module tb_stream_take_sum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dIn;
  logic [7:0] sIn;
  logic       sIn_valid;
  logic       sIn_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dOut;

  int n_tests = 0;
  int n_fail  = 0;

  stream_take_sum #(.intN(8), .CNTW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dIn       (dIn),
    .sIn       (sIn),
    .sIn_valid (sIn_valid),
    .sIn_ready (sIn_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dOut      (dOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] n);
    check("start_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dIn      = n;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic v);
    sIn       = d;
    sIn_valid = v;
    tick();
    sIn_valid = 1'b0;
  endtask

  task automatic accept(input logic [7:0] exp);
    check("acc_out_valid", 32'(out_valid), 32'd1);
    check("acc_dout", 32'(dOut), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_dout", 32'(dOut), 32'd0);
  endtask

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
`ifdef STREAM_TAKE_SUM_SAT_EN
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7f;
`endif
    return s[7:0];
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; dIn = '0; sIn = '0; sIn_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sin_ready", 32'(sIn_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dOut), 32'd0);
    rst = 1'b0;
    tick();

    // 3 elements back to back: result visible after the third beat edge
    start(8'd3);
    check("t1_sin_ready", 32'(sIn_ready), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    beat(8'd42, 1'b1);
    check("t1_ov_b1", 32'(out_valid), 32'd0);
    beat(8'd1, 1'b1);
    check("t1_ov_b2", 32'(out_valid), 32'd0);
    beat(8'd2, 1'b1);
    check("t1_sin_ready_done", 32'(sIn_ready), 32'd0);
    tick();
    check("t1_hold_dout", 32'(dOut), 32'd45);
    accept(8'd45);

    // zero and negative counts complete immediately
    start(8'd0);
    check("t2_zero_sin_ready", 32'(sIn_ready), 32'd0);
    accept(8'd0);
    start(8'hfb);
    check("t2_neg_sin_ready", 32'(sIn_ready), 32'd0);
    accept(8'd0);

    // stalls between beats lose nothing
    start(8'd4);
    for (int i = 0; i < 7; i++) begin
      check("t3_sin_ready", 32'(sIn_ready), 32'd1);
      beat((i % 2 == 0) ? 8'((i / 2 + 1) * 10) : 8'hee, (i % 2 == 0));
    end
    accept(8'd100);

    // overflow held while sink stalls
    start(8'd2);
    beat(8'd100, 1'b1);
    beat(8'd100, 1'b1);
    for (int i = 0; i < 5; i++) begin
`ifdef STREAM_TAKE_SUM_SAT_EN
      check("t4_hold", 32'(dOut), 32'h7f);
`else
      check("t4_hold", 32'(dOut), 32'hc8);
`endif
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
`ifdef STREAM_TAKE_SUM_SAT_EN
    accept(8'h7f);
`else
    accept(8'hc8);
`endif

    // boundary wraps: 127+1 and -100 + -100
    start(8'd2);
    beat(8'd127, 1'b1);
    beat(8'd1, 1'b1);
`ifdef STREAM_TAKE_SUM_SAT_EN
    accept(8'h7f);
`else
    accept(8'h80);
`endif
    start(8'd2);
    beat(8'h9c, 1'b1);
    beat(8'h9c, 1'b1);
`ifdef STREAM_TAKE_SUM_SAT_EN
    accept(8'h80);
`else
    accept(8'h38);
`endif

    // asynchronous reset mid-run discards the partial sum
    start(8'd5);
    beat(8'd1, 1'b1);
    beat(8'd2, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_sin_ready", 32'(sIn_ready), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_dout", 32'(dOut), 32'd0);
    rst = 1'b0;
    tick();
    start(8'd1);
    beat(8'd7, 1'b1);
    accept(8'd7);

    // random handshakes against a reference model
    begin
      int         m_st = 0;
      int         m_cnt = 0;
      logic [7:0] m_sum = '0;
      int         nv;
      for (int c = 0; c < 1000; c++) begin
        check("rnd_in_ready", 32'(in_ready), 32'(m_st == 0));
        check("rnd_sin_ready", 32'(sIn_ready), 32'(m_st == 1));
        check("rnd_out_valid", 32'(out_valid), 32'(m_st == 2));
        check("rnd_dout", 32'(dOut), (m_st == 2) ? 32'(m_sum) : 32'd0);
        in_valid  = 1'($urandom_range(0, 1));
        dIn       = 8'($urandom_range(0, 6)) - 8'd1;
        sIn       = 8'($urandom);
        sIn_valid = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        case (m_st)
          0: if (in_valid) begin
            nv    = dIn[7] ? 0 : int'(dIn);
            m_sum = '0;
            m_cnt = nv;
            m_st  = (nv == 0) ? 2 : 1;
          end
          1: if (sIn_valid) begin
            m_sum = add8(m_sum, sIn);
            m_cnt--;
            if (m_cnt == 0) m_st = 2;
          end
          default: if (out_ready) m_st = 0;
        endcase
        tick();
      end
      in_valid = 1'b0; sIn_valid = 1'b0; out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
